// File: rtl/rgb_led_arbiter.sv
// Round-robin owner arbiter for the shared active-low RGB LED, with minimum dwell and a blank gap between owners.
// Latency: grant, busy and pins are registered; request, release and colour changes show after one clock edge.
// Backpressure: none; requesters hold req level-high and wait for grant. Optional LED_ARB_PRIORITY_EN gives requester 0 priority and preemption.
module rgb_led_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = 2000000,
  parameter int GAP_CYCLES   = 12000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   color_in,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   RGB_R,
  output logic                   RGB_G,
  output logic                   RGB_B
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int DW_W  = $clog2(DWELL_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, OWN, BLANK} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_nxt;
  logic [DW_W-1:0]    dwell_cnt, dwell_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic               busy_nxt;
  logic [2:0]         rgb_q, rgb_nxt;

  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] own_mask;
  logic               preempt;
  logic               do_arb;

  assign RGB_R = rgb_q[2];
  assign RGB_G = rgb_q[1];
  assign RGB_B = rgb_q[0];

  // Pick the first requester after rr_ptr (the last owner), wrapping; the last owner is lowest priority.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
`ifdef LED_ARB_PRIORITY_EN
    if (req[0]) begin
      win_vld = 1'b1;
      win_idx = '0;
    end
`endif
  end

  // Current owner mask, used to detect contention from any other requester.
  always_comb begin
    own_mask        = '0;
    own_mask[owner] = 1'b1;
`ifdef LED_ARB_PRIORITY_EN
    preempt = req[0] && (owner != '0);
`else
    preempt = 1'b0;
`endif
  end

  // Next-state logic and the next values of the registered outputs.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    dwell_nxt = dwell_cnt;
    gap_nxt   = gap_cnt;
    grant_nxt = '0;
    busy_nxt  = 1'b0;
    rgb_nxt   = 3'b111;
    do_arb    = 1'b0;
    case (state)
      IDLE: do_arb = 1'b1;
      OWN: begin
        busy_nxt = 1'b1;
        // Release wins over everything; hand-over only once the dwell has been served.
        if (!req[owner] || preempt ||
            ((dwell_cnt >= DW_W'(DWELL_CYCLES)) && |(req & ~own_mask))) begin
          state_nxt = BLANK;
          gap_nxt   = GAP_W'(1);
        end else begin
          if (dwell_cnt < DW_W'(DWELL_CYCLES)) dwell_nxt = dwell_cnt + 1'b1;
          grant_nxt        = '0;
          grant_nxt[owner] = 1'b1;
          rgb_nxt          = ~color_in[3*owner +: 3];
        end
      end
      BLANK: begin
        if (gap_cnt >= GAP_W'(GAP_CYCLES)) begin
          do_arb = 1'b1;
        end else begin
          gap_nxt  = gap_cnt + 1'b1;
          busy_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (do_arb) begin
      if (win_vld) begin
        state_nxt          = OWN;
        owner_nxt          = win_idx;
        rr_nxt             = win_idx;
        dwell_nxt          = DW_W'(1);
        grant_nxt[win_idx] = 1'b1;
        rgb_nxt            = ~color_in[3*win_idx +: 3];
        busy_nxt           = 1'b1;
      end else begin
        state_nxt = IDLE;
        dwell_nxt = '0;
        gap_nxt   = '0;
      end
    end
  end

  // State, counters and registered outputs; reset blanks the LED immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= IDX_W'(NUM_REQ - 1);
      dwell_cnt <= '0;
      gap_cnt   <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      rgb_q     <= 3'b111;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_nxt;
      dwell_cnt <= dwell_nxt;
      gap_cnt   <= gap_nxt;
      grant     <= grant_nxt;
      busy      <= busy_nxt;
      rgb_q     <= rgb_nxt;
    end
  end

endmodule
